// File: rtl/mvm_rf_write_decoder.sv
// mvm_rf_write_decoder
// Decodes AXI-Stream packets into register-file writes. The header beat
// selects one RF (one-hot) and a start address. Following beats stream into
// consecutive addresses. Malformed headers are counted, and the rest of that
// packet is dropped. The RF write port is a single output register that
// advances whenever the bank takes the pending write.
module mvm_rf_write_decoder #(
  parameter int unsigned           DATAW   = 512,
  parameter int unsigned           USERW   = 76,
  parameter int unsigned           DESTW   = 12,
  parameter int unsigned           NUM_RF  = 64,
  parameter int unsigned           ADDRW   = 9,
  parameter logic [DESTW-1:0]      NODE_ID = 12'h002
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              axis_s_tvalid,
  input  logic [DATAW-1:0]  axis_s_tdata,
  input  logic [USERW-1:0]  axis_s_tuser,
  input  logic [DESTW-1:0]  axis_s_tdest,
  input  logic              axis_s_tlast,
  output logic              axis_s_tready,
  output logic [NUM_RF-1:0] rf_wr_en,
  output logic [ADDRW-1:0]  rf_wr_addr,
  output logic [DATAW-1:0]  rf_wr_data,
  input  logic              rf_wr_ready,
  output logic [31:0]       wr_count,
  output logic [15:0]       err_count,
  output logic              err_sticky
);

  localparam int unsigned SEL_LSB = 11;

  typedef enum logic [1:0] {IDLE, BURST, DROP} state_t;

  state_t              state_q, state_d;
  logic [NUM_RF-1:0]   sel_q, sel_d;
  logic [ADDRW-1:0]    addr_q, addr_d;
  logic [NUM_RF-1:0]   en_q, en_d;
  logic [ADDRW-1:0]    oaddr_q, oaddr_d;
  logic [DATAW-1:0]    odata_q, odata_d;
  logic [31:0]         wr_cnt_q, wr_cnt_d;
  logic [15:0]         err_cnt_q, err_cnt_d;
  logic                sticky_q, sticky_d;
  logic                live_q;

  logic [NUM_RF-1:0]   hdr_sel;
  logic [ADDRW-1:0]    hdr_addr;
  logic                hdr_ok;
  logic                out_valid;
  logic                accept;
  logic                wr_done;
  logic                unused_tuser;

  // Header fields: RF select, start address and opcode live in tuser.
  assign hdr_sel   = axis_s_tuser[SEL_LSB +: NUM_RF];
  assign hdr_addr  = axis_s_tuser[ADDRW-1:0];
  assign hdr_ok    = (axis_s_tuser[10:9] == 2'b11) &&
                     (axis_s_tdest == NODE_ID) && $onehot(hdr_sel);

  // Bits of tuser above the select field carry nothing for this block.
  assign unused_tuser = ^axis_s_tuser;

  assign out_valid = |en_q;
  assign wr_done   = out_valid && rf_wr_ready;
  // live_q keeps tready low through reset and for the edge that releases it.
  assign axis_s_tready = live_q && (!out_valid || rf_wr_ready);
  assign accept    = axis_s_tvalid && axis_s_tready;

  assign rf_wr_en   = en_q;
  assign rf_wr_addr = oaddr_q;
  assign rf_wr_data = odata_q;
  assign wr_count   = wr_cnt_q;
  assign err_count  = err_cnt_q;
  assign err_sticky = sticky_q;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values.
      state_q <= state_d;
    end
  end

  // Next-state: packet framing follows tlast on every accepted beat.
  always_comb begin
    // NOTE: default first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    if (accept) begin
      unique case (state_q)
        IDLE:    if (!axis_s_tlast) state_d = hdr_ok ? BURST : DROP;
        BURST,
        DROP:    if (axis_s_tlast)  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs: load the write register, track the burst pointer, count events.
  always_comb begin
    sel_d     = sel_q;
    addr_d    = addr_q;
    en_d      = en_q;
    oaddr_d   = oaddr_q;
    odata_d   = odata_q;
    wr_cnt_d  = wr_cnt_q + 32'(wr_done);
    err_cnt_d = err_cnt_q;
    sticky_d  = sticky_q;

    if (accept && state_q == IDLE && hdr_ok) begin
      sel_d   = hdr_sel;
      addr_d  = hdr_addr + 1'b1;
      en_d    = hdr_sel;
      oaddr_d = hdr_addr;
      odata_d = axis_s_tdata;
    end else if (accept && state_q == BURST) begin
      // Address wraps naturally at 2^ADDRW.
      addr_d  = addr_q + 1'b1;
      en_d    = sel_q;
      oaddr_d = addr_q;
      odata_d = axis_s_tdata;
    end else if (wr_done) begin
      en_d    = '0;
    end

    if (accept && state_q == IDLE && !hdr_ok) begin
      sticky_d = 1'b1;
      if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  // Datapath and status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q     <= '0;
      addr_q    <= '0;
      en_q      <= '0;
      oaddr_q   <= '0;
      odata_q   <= '0;
      wr_cnt_q  <= '0;
      err_cnt_q <= '0;
      sticky_q  <= 1'b0;
      live_q    <= 1'b0;
    end else begin
      sel_q     <= sel_d;
      addr_q    <= addr_d;
      en_q      <= en_d;
      oaddr_q   <= oaddr_d;
      odata_q   <= odata_d;
      wr_cnt_q  <= wr_cnt_d;
      err_cnt_q <= err_cnt_d;
      sticky_q  <= sticky_d;
      live_q    <= 1'b1;
    end
  end

endmodule

// File: doc/mvm_rf_write_decoder.md
MVM_RF_WRITE_DECODER -- requirements
Module: mvm_rf_write_decoder

Interface
REQ-001 SHALL have parameter DATAW, default 512: AXIS data width and RF word width.
REQ-002 SHALL have parameter USERW, default 76: AXIS tuser width.
REQ-003 SHALL have parameter DESTW, default 12: AXIS tdest width.
REQ-004 SHALL have parameter NUM_RF, default 64: number of register files, selected one-hot by tuser[11 +: NUM_RF].
REQ-005 SHALL have parameter ADDRW, default 9: RF word address width, carried in tuser[ADDRW-1:0].
REQ-006 SHALL have parameter NODE_ID, default 12'h002: tdest value this node accepts.
REQ-007 SHALL have port clk, input, 1 bit: single clock for all logic.
REQ-008 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-009 SHALL have AXIS slave inputs: axis_s_tvalid (1), axis_s_tdata (DATAW), axis_s_tuser (USERW), axis_s_tdest (DESTW), axis_s_tlast (1).
REQ-010 SHALL have port axis_s_tready, output, 1 bit: slave ready.
REQ-011 SHALL have outputs rf_wr_en (NUM_RF, one-hot), rf_wr_addr (ADDRW) and rf_wr_data (DATAW): the registered RF write port.
REQ-012 SHALL have port rf_wr_ready, input, 1 bit: RF bank accepts the pending write.
REQ-013 SHALL have status outputs wr_count (32), err_count (16) and err_sticky (1).

Function
REQ-014 SHALL transfer a beat only when axis_s_tvalid and axis_s_tready are both high at a clk rising edge.
REQ-015 SHALL drive axis_s_tready = !out_valid || rf_wr_ready, where out_valid = |rf_wr_en; dropped beats are also subject to this rule.
REQ-016 SHALL implement FSM states IDLE, BURST and DROP; the first beat of a packet is accepted in IDLE.
REQ-017 SHALL treat an IDLE beat as valid when tuser[10:9]==2'b11, tdest==NODE_ID and tuser[11 +: NUM_RF] has exactly one bit set.
REQ-018 For a valid IDLE beat, SHALL drive on the next cycle: rf_wr_en = the select, rf_wr_addr = tuser[ADDRW-1:0], rf_wr_data = tdata.
REQ-019 For a valid IDLE beat, SHALL latch the select and addr+1; the next state is BURST if tlast==0, else IDLE.
REQ-020 In BURST, SHALL ignore tuser and tdest on each beat and write tdata to the latched RF at the latched address, then increment the latched address.
REQ-021 In BURST, SHALL return to IDLE on tlast.
REQ-022 SHALL wrap the burst address modulo 2^ADDRW (511 -> 0) without raising an error.
REQ-023 For an invalid IDLE beat, SHALL issue no write, increment err_count and set err_sticky.
REQ-024 After an invalid IDLE beat, SHALL go to DROP if tlast==0, else stay in IDLE.
REQ-025 In DROP, SHALL accept and discard beats with no writes and no further error counts, and return to IDLE on tlast.
REQ-026 Write latency SHALL be exactly 1 cycle from acceptance to rf_wr_en asserted.
REQ-027 SHALL hold rf_wr_en, rf_wr_addr and rf_wr_data stable while rf_wr_ready==0.
REQ-028 A write SHALL complete on a cycle with out_valid && rf_wr_ready; in the same cycle a new accepted beat SHALL load the output register, giving back-to-back writes at 1 per cycle.
REQ-029 SHALL clear rf_wr_en after a write completes with no new beat accepted.
REQ-030 SHALL increment wr_count by 1 on each completed write, wrapping at 2^32.
REQ-031 SHALL saturate err_count at 16'hFFFF.
REQ-032 err_sticky SHALL clear only on reset.

Reset
REQ-033 On rst, SHALL asynchronously set FSM=IDLE, rf_wr_en=0, rf_wr_addr=0, rf_wr_data=0, wr_count=0, err_count=0 and err_sticky=0.
REQ-034 During rst, SHALL drive axis_s_tready=0; tready SHALL rise on the first clk edge after rst deasserts.
REQ-035 Reset mid-burst or mid-drop SHALL abandon the packet with no pending write retained; the next accepted beat is treated as a header.

Verification
REQ-036 Single beat: tuser[8:0]=9'h1, tuser[10:9]=2'b11, tuser[11]=1, tdest=12'h002, tlast=1, rf_wr_ready=1 -> next cycle rf_wr_en=64'h1, addr=1, data=tdata; wr_count=1.
REQ-037 Sweep: 64 single-beat packets selecting tuser bits 11..74 back-to-back -> 64 consecutive writes, rf_wr_en walks 1<<0 .. 1<<63, no stall cycles, wr_count=64.
REQ-038 Burst: header addr=9'h1FE, select bit 20 set, 4 beats -> writes to RF 9 at addrs 1FE, 1FF, 000, 001; err_count=0.
REQ-039 Errors: select=0, a two-hot select, op=2'b01 and tdest=12'h003, each as a 3-beat packet -> no writes, err_count=4, err_sticky=1, all 12 beats accepted.
REQ-040 Backpressure: rf_wr_ready=0 for 5 cycles during a stream -> outputs held stable, axis_s_tready=0, no data lost or duplicated once ready returns.
REQ-041 Reset mid-burst: assert rst after 2 of 4 burst beats -> outputs cleared immediately; the next packet decodes correctly as a header.
